// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and defaults for the key debouncer
package key_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;
  localparam int KEY_DEBOUNCE_DEFAULT = 1_000_000;
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key's synchroniser, stability counter and debounce FSM
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  logic [1:0] sync;
  logic key_s;
  logic done;
  key_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic level_nx, press_nx, release_nx;
  assign key_s = sync[1];
  assign done = cnt == CNT_MAX;
  // next state: a change is accepted only after DEBOUNCE_CYC stable samples
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    level_nx = key_level;
    press_nx = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE: state_nx = key_s ? IDLE : PRESS_WAIT;
      PRESS_WAIT:
        if (key_s) state_nx = IDLE;
        else if (done) begin
          state_nx = PRESSED;
          level_nx = 1'b1;
          press_nx = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
      PRESSED: state_nx = key_s ? RELEASE_WAIT : PRESSED;
      RELEASE_WAIT:
        if (!key_s) state_nx = PRESSED;
        else if (done) begin
          state_nx = IDLE;
          level_nx = 1'b0;
          release_nx = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
    endcase
  end
  // synchroniser resets to released so a key held through reset is re-qualified
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      state <= state_nx;
      cnt <= cnt_nx;
      key_level <= level_nx;
      key_press <= press_nx;
      key_release <= release_nx;
    end
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: independent debounced level and press/release pulses per key
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W = 2,
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);
  for (genvar i = 0; i < KEY_W; i++) begin : g_chan
    key_debounce_chan #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_chan (
      .sys_clk(sys_clk),
      .rst(rst),
      .key(key[i]),
      .key_level(key_level[i]),
      .key_press(key_press[i]),
      .key_release(key_release[i])
    );
  end
endmodule
